pdm_decimator: RTL and testbench
================================

// Module: pdm_decimator
// PURPOSE
//   Receive side of the 1-bit PDM audio path: converts a PDM bitstream back into
//   16-bit unsigned PCM samples, the same format the pdm modulator consumes.
//   3rd-order CIC decimator (integrators at bit rate, combs at sample rate).
//   Used for modulator loopback checks and for external PDM mic/line input on uio.
// PARAMETERS
//   DEC_LOG2  5   log2 of decimation ratio R (R = 2^DEC_LOG2 = 32); legal 2..5
//   OUT_W     16  output sample width; must satisfy OUT_W >= 3*DEC_LOG2
// PORTS
//   clk           in   1      system clock (single clock domain)
//   reset         in   1      asynchronous, active-high reset
//   pdm_in        in   1      PDM bit; 1 = +full-scale, 0 = zero
//   pdm_en        in   1      bit strobe; pdm_in is consumed only on cycles with pdm_en=1
//   sample_out    out  OUT_W  decimated unsigned PCM sample, held between updates
//   sample_valid  out  1      one-cycle pulse when sample_out is updated
// BEHAVIOUR
//   - Internal width W = 3*DEC_LOG2 + 1 (16 at default); all CIC arithmetic is
//     modulo 2^W, unsigned. Integrator wrap-around is intended and must not saturate.
//   - Reset (async, immediate, also mid-operation): integrators i1..i3, comb delays
//     d1..d3, decimation counter, sample_out=0, sample_valid=0. Counting restarts
//     from 0 on release. No partial sample is emitted across a reset.
//   - Integrators, on pdm_en=1 only: i1<=i1+pdm_in; i2<=i2+i1; i3<=i3+i2 (registered,
//     old values on the right). On pdm_en=0 all state holds.
//   - Decimation counter cnt (DEC_LOG2 bits) increments on each pdm_en=1 and wraps
//     R-1 -> 0. The enabled cycle with cnt==R-1 is the decimation instant.
//   - At the decimation instant, combinationally from the post-update i3 value:
//     c1=i3n-d1; c2=c1-d2; c3=c2-d3; registered at that edge: d1<=i3n, d2<=c1, d3<=c2.
//   - Output scaling: y = c3 (0..2^(W-1)); if y==2^(W-1) clamp to 2^(W-1)-1;
//     sample_out = y << (OUT_W-(W-1)), low bits zero. Default: y in 0..0x7FFF,
//     sample_out = y<<1, so full-scale ones give 0xFFFE.
//   - Latency: sample_out/sample_valid update on the clock edge following the
//     decimation instant (1 cycle). sample_valid is high for exactly one cycle per
//     R enabled bits, independent of pdm_en duty cycle.
//   - Startup: the first 3 samples after reset are CIC settling transients (values
//     unspecified but in range); from the 4th sample output is exact for a
//     stationary input.
//   - pdm_en held low: no integration, no samples, outputs hold last values.
//   - pdm_en=1 on the cycle reset deasserts: bit is consumed normally (cnt 0 -> 1).
// TESTING
//   1. pdm_en=1 continuous, pdm_in=0 for 8*R bits -> every sample_out=0x0000,
//      sample_valid pulses every 32 cycles.
//   2. pdm_in=1 continuous -> samples 4..N == 0xFFFE (clamp exercised), no wrap glitch
//      after >2^16 cycles of integration.
//   3. pdm_in alternating 1,0 -> samples 4..N == 0x8000; pdm_in pattern 1,0,0,0 -> 0x4000.
//   4. pdm_en asserted every 3rd cycle, pdm_in=1 -> sample_valid period 96 cycles,
//      values identical to test 2; held low 500 cycles -> no pulses, output held.
//   5. Loopback: pdm modulator driven with constant 0x4000 -> pdm_decimator output
//      settles to 0x4000 +/- 0x0400 on every sample after the 4th.
//   6. Async reset pulsed mid-frame (cnt=17) -> sample_out=0, sample_valid=0 same
//      cycle; first post-release sample_valid exactly 33 cycles after release (R bits + 1).

Source files
------------

// File: rtl/pdm_decimator.sv
// Third-order CIC decimator that turns a 1-bit PDM stream into unsigned PCM samples.
// The integrators run on enabled bits. The combs run once per R bits, and the output is registered one cycle later.
module pdm_decimator #(
    parameter int DEC_LOG2 = 5,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             pdm_en,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid
);

    localparam int W     = 3*DEC_LOG2 + 1;
    localparam int SHIFT = OUT_W - (W-1);

    typedef logic [W-1:0] acc_t;

    // Full scale (2^(W-1)) does not fit in W-1 bits, so it is clamped.
    // Settling transients that wrap negative are clamped as well.
    function automatic logic [OUT_W-1:0] scale_sat(input acc_t c);
        logic [W-2:0]     y;
        logic [OUT_W-1:0] ext;
        y   = c[W-1] ? {(W-1){1'b1}} : c[W-2:0];
        ext = OUT_W'(y);
        return ext << SHIFT;
    endfunction

    acc_t i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    acc_t d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    acc_t c3_q, c3_d;
    acc_t i3n, c1, c2, c3;
    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic                dec_q, dec_d;
    logic [OUT_W-1:0]    sample_q, sample_d;
    logic                valid_q, valid_d;

    always_comb begin
        i1_d     = i1_q;
        i2_d     = i2_q;
        i3_d     = i3_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        c3_d     = c3_q;
        cnt_d    = cnt_q;
        dec_d    = 1'b0;
        i3n      = i3_q + i2_q;
        c1       = i3n - d1_q;
        c2       = c1 - d2_q;
        c3       = c2 - d3_q;

        // Stage 0: integrators at bit rate; combs at the decimation instant.
        if (pdm_en) begin
            i1_d  = i1_q + acc_t'(pdm_in);
            i2_d  = i2_q + i1_q;
            i3_d  = i3n;
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                dec_d = 1'b1;
                c3_d  = c3;
                d1_d  = i3n;
                d2_d  = c1;
                d3_d  = c2;
            end
        end

        // Stage 1: scale and publish the comb result one cycle later.
        valid_d  = dec_q;
        sample_d = dec_q ? scale_sat(c3_q) : sample_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            c3_q     <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            c3_q     <= c3_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator (R = 32): constant, periodic, strobed, loopback and reset cases.
// The expected values come from the CIC DC gain R^3 = 2^15 and the modulator duty cycle.
module tb_pdm_decimator;

    localparam int R = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        pdm_in;
    logic        pdm_en;
    logic [15:0] sample_out;
    logic        sample_valid;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] smp[$];
    int          scyc[$];

    always #5 clk = ~clk;

    pdm_decimator #(.DEC_LOG2(5), .OUT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .pdm_in       (pdm_in),
        .pdm_en       (pdm_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en, input logic din);
        pdm_en = en;
        pdm_in = din;
        @(posedge clk);
        #1;
        cyc++;
        if (sample_valid) begin
            smp.push_back(sample_out);
            scyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        pdm_en = 1'b0;
        pdm_in = 1'b0;
        reset  = 1'b1;
        #3;
        reset  = 1'b0;
        cyc    = 0;
        smp.delete();
        scyc.delete();
    endtask

    initial begin
        logic [15:0] acc;
        logic [16:0] s;
        int          n;
        int          first;

        reset  = 1'b1;
        pdm_en = 1'b0;
        pdm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sample", 32'(sample_out), 32'h0);
        check("reset_valid", 32'(sample_valid), 32'h0);
        reset = 1'b0;
        cyc = 0;

        // All zeros: every sample is zero and the strobe period is R.
        do_reset();
        for (int i = 0; i < 8*R + 1; i++) tick(1'b1, 1'b0);
        check("zero_count", 32'(smp.size()), 32'd8);
        if (scyc.size() > 0) check("zero_first_cyc", 32'(scyc[0]), 32'd33);
        for (int i = 0; i < smp.size(); i++) begin
            check($sformatf("zero[%0d]", i), 32'(smp[i]), 32'h0);
            if (i > 0) check($sformatf("zero_period[%0d]", i), 32'(scyc[i] - scyc[i-1]), 32'd32);
        end

        // All ones for more than 2^16 bits: full scale is clamped and wrap-around is harmless.
        do_reset();
        for (int i = 0; i < 2100*R + 1; i++) tick(1'b1, 1'b1);
        check("ones_count", 32'(smp.size()), 32'd2100);
        for (int i = 3; i < smp.size(); i++)
            check($sformatf("ones[%0d]", i), 32'(smp[i]), 32'hFFFE);

        // Alternating 1,0 pattern: half scale.
        do_reset();
        for (int i = 0; i < 8*R + 1; i++) tick(1'b1, (i % 2) == 0);
        check("alt_count", 32'(smp.size()), 32'd8);
        for (int i = 3; i < smp.size(); i++)
            check($sformatf("alt[%0d]", i), 32'(smp[i]), 32'h8000);

        // Repeating 1,0,0,0 pattern: quarter scale.
        do_reset();
        for (int i = 0; i < 8*R + 1; i++) tick(1'b1, (i % 4) == 0);
        check("quarter_count", 32'(smp.size()), 32'd8);
        for (int i = 3; i < smp.size(); i++)
            check($sformatf("quarter[%0d]", i), 32'(smp[i]), 32'h4000);

        // Strobe on every third cycle: output period is 3R and values match all-ones.
        do_reset();
        for (int i = 0; i < 1000; i++) tick((i % 3) == 0, 1'b1);
        check("sparse_count", 32'(smp.size()), 32'd10);
        if (scyc.size() > 0) check("sparse_first_cyc", 32'(scyc[0]), 32'd95);
        for (int i = 1; i < smp.size(); i++)
            check($sformatf("sparse_period[%0d]", i), 32'(scyc[i] - scyc[i-1]), 32'd96);
        for (int i = 3; i < smp.size(); i++)
            check($sformatf("sparse[%0d]", i), 32'(smp[i]), 32'hFFFE);
        n = smp.size();
        for (int i = 0; i < 500; i++) tick(1'b0, 1'b1);
        check("hold_no_pulse", 32'(smp.size()), 32'(n));
        check("hold_sample", 32'(sample_out), 32'hFFFE);
        check("hold_valid", 32'(sample_valid), 32'h0);

        // Loopback through a first-order sigma-delta modulator fed 0x4000.
        do_reset();
        acc = 16'h0;
        for (int i = 0; i < 10*R + 1; i++) begin
            s   = {1'b0, acc} + 17'h04000;
            acc = s[15:0];
            tick(1'b1, s[16]);
        end
        check("loop_count", 32'(smp.size()), 32'd10);
        for (int i = 4; i < smp.size(); i++)
            check($sformatf("loop_in_range[%0d]", i),
                  32'((smp[i] >= 16'h3C00) && (smp[i] <= 16'h4400)), 32'd1);

        // Reset asserted mid-frame at cnt = 17, then the first strobe after release.
        do_reset();
        for (int i = 0; i < 4*R + 17; i++) tick(1'b1, 1'b1);
        check("pre_rst_sample", 32'(sample_out), 32'hFFFE);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_sample", 32'(sample_out), 32'h0);
        check("midrst_valid", 32'(sample_valid), 32'h0);
        #1;
        reset = 1'b0;
        cyc = 0;
        smp.delete();
        scyc.delete();
        for (int i = 0; i < 60 && smp.size() == 0; i++) tick(1'b1, 1'b1);
        first = (scyc.size() > 0) ? scyc[0] : 0;
        check("post_rst_first_cyc", 32'(first), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
